apix_link_core: RTL and testbench
=================================

Name: apix_link_core

Overview:
- Single-clock APIX-style pixel link core containing a transmitter and a receiver.
- Transmitter serializes 24-bit RGB pixels into framed bits on apix_data, with a companion bit strobe apix_clk.
- Receiver deserializes apix_data_in/apix_clk_in, checks framing and parity, and presents the recovered pixel.
- The TX outputs and RX inputs are separate ports; system and bench loop them back externally.

Parameters:
- BIT_CYCLES, 2: clk cycles per serial bit. Must be even and ≥2.
- RX_TIMEOUT, 8: clk cycles without an apix_clk_in rising edge, mid-frame, before the RX aborts the frame.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_data_in  in  24  pixel to transmit, {R,G,B}.
- pixel_valid  in  1  one-cycle request to send pixel_data_in.
- pixel_ready  out  1  high when the TX holding register is empty.
- tx_overflow  out  1  sticky; set when a request is dropped.
- apix_data  out  1  serial data.
- apix_clk  out  1  serial bit strobe.
- apix_data_in  in  1  serial data to the RX.
- apix_clk_in  in  1  bit strobe to the RX.
- pixel_data_out  out  24  last correctly received pixel.
- pixel_out_valid  out  1  one-cycle pulse per good frame.
- error_flag  out  1  last frame bad (parity, stop bit or timeout).

Behaviour:
- Reset: every output is 0 except pixel_ready=1. TX and RX return to IDLE and the holding register empties. A reset mid-frame aborts the frame immediately.

Frame format:
- 27 bits, sent in this order: start bit = 1; pixel bits 23..0 (MSB first); even-parity bit = XOR of the 24 data bits; stop bit = 0.
- Line idle state: apix_data=0, apix_clk=0.

TX timing:
- Each bit occupies BIT_CYCLES cycles. apix_clk is 0 for the first BIT_CYCLES/2 cycles and 1 for the second half.
- apix_data changes only at bit start. Both outputs are registered.

TX accept rules:
- pixel_valid while TX is IDLE: the pixel is loaded on that edge N, and the start bit is driven from after edge N.
- pixel_valid while a frame is in progress and holding is empty: the pixel is stored in holding and pixel_ready goes 0.
- pixel_valid while holding is full: the request is dropped and tx_overflow=1 until reset.
- At the end of a frame (edge N+27*BIT_CYCLES), a held pixel starts its frame on that same edge with no idle gap, and pixel_ready returns to 1.
- At the end of a frame with nothing held, TX returns to IDLE.

RX sampling:
- Registers the previous apix_clk_in.
- Samples apix_data_in on any edge where apix_clk_in=1 and prev=0.
- No metastability synchronizer (same clock domain).

RX states:
- IDLE: a sampled 1 is taken as the start bit and moves to DATA; a sampled 0 is ignored.
- DATA: collect 24 bits, then PARITY, then STOP.
- On the stop-bit sample, if parity matches and stop=0: pixel_data_out is loaded, pixel_out_valid pulses for one cycle, and error_flag=0.
- Otherwise (bad parity or stop bit): pixel_data_out holds its value, there is no valid pulse, and error_flag=1.
- The state then returns to IDLE.
- Timeout: in any non-IDLE state, RX_TIMEOUT cycles without a rising edge forces IDLE, sets error_flag=1, and produces no valid pulse.
- error_flag holds its value until the next frame completes or times out.

Latency:
- Loopback latency from the accept edge N to the pixel_out_valid edge is 26*BIT_CYCLES + BIT_CYCLES/2 + 1 cycles (54 at default).

Test Plan:
1. Reset, then pixel 24'hFF00FF for one cycle → apix_data shows 1, FF00FF bits MSB first, parity 0, stop 0. pixel_data_out=FF00FF with a valid pulse 54 cycles after accept; error_flag=0.
2. Pixel FF00FF, then 24'h000001 three cycles later → pixel_ready=0 until edge N+54. The second frame starts at N+54 with parity bit 1. Outputs are FF00FF, then 000001 at N+108; tx_overflow=0.
3. Three valid pulses within one frame → the third is dropped and tx_overflow=1. Exactly two pixels are received; a later reset clears tx_overflow.
4. Bench inverts the parity bit of a 00FF00 frame in the loopback → error_flag=1, no valid pulse, pixel_data_out keeps its prior value. A following good frame 123456 restores error_flag=0.
5. Bench forces apix_clk_in low from the 10th bit → error_flag=1 after 8 cycles and RX returns to IDLE. The next clean frame is received correctly.
6. Assert rst for one cycle midway through a frame → all outputs return to reset values at the next edge. A new pixel ABCDEF sent afterwards is received correctly.

Source files
------------

// File: rtl/apix_link_core.sv
// APIX-style pixel link: framed serial transmitter with one-deep holding register,
// plus a strobe-sampled receiver with parity/stop checking and a stall timeout.
//
// TX state | meaning
// ---------+--------------------------------------------
// TX_IDLE  | line idle, data=0 clk=0, holding empty
// TX_BUSY  | a 27-bit frame is being shifted out
//
// RX state | meaning
// ---------+--------------------------------------------
// RX_IDLE  | waiting for a sampled 1 (start bit)
// RX_DATA  | collecting 24 pixel bits, MSB first
// RX_PAR   | next sample is the even-parity bit
// RX_STOP  | next sample is the stop bit; frame verdict
module apix_link_core #(
    parameter int BIT_CYCLES = 2,
    parameter int RX_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_data_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        tx_overflow,
    output logic        apix_data,
    output logic        apix_clk,
    input  logic        apix_data_in,
    input  logic        apix_clk_in,
    output logic [23:0] pixel_data_out,
    output logic        pixel_out_valid,
    output logic        error_flag
);

    localparam int PW = $clog2(BIT_CYCLES);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CYCLES / 2);
    localparam logic [4:0]    LAST_BIT = 5'd26;
    localparam logic [TW-1:0] TO_LOAD  = TW'(RX_TIMEOUT - 1);

    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [PW-1:0] ph_q, ph_d, ph_dec;
    logic [4:0]  bits_q, bits_d;
    logic [26:0] sreg_q, sreg_d;
    logic        aclk_q, aclk_d;
    logic        hold_full_q, hold_full_d;
    logic [23:0] hold_q, hold_d;
    logic        ovf_q, ovf_d;
    logic        bit_end, frame_end, start_new;
    logic [23:0] start_pix;

    // Phase and bit counters both count down; a frame ends when both hit zero.
    assign bit_end   = (tx_state_q == TX_BUSY) && (ph_q == '0);
    assign frame_end = bit_end && (bits_q == '0);
    assign start_new = ((tx_state_q == TX_IDLE) && pixel_valid) ||
                       (frame_end && (hold_full_q || pixel_valid));
    assign start_pix = (frame_end && hold_full_q) ? hold_q : pixel_data_in;
    assign ph_dec    = ph_q - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) tx_state_q <= TX_IDLE;
        else     tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (pixel_valid) tx_state_d = TX_BUSY;
            TX_BUSY: if (frame_end && !start_new) tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        sreg_d      = sreg_q;
        ph_d        = ph_q;
        bits_d      = bits_q;
        aclk_d      = aclk_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        ovf_d       = ovf_q;
        if (start_new) begin
            sreg_d = {1'b1, start_pix, ^start_pix, 1'b0};
            ph_d   = PH_LAST;
            bits_d = LAST_BIT;
            aclk_d = 1'b0;
        end else if (frame_end) begin
            sreg_d = '0;
            aclk_d = 1'b0;
        end else if (bit_end) begin
            sreg_d = {sreg_q[25:0], 1'b0};
            ph_d   = PH_LAST;
            bits_d = bits_q - 5'd1;
            aclk_d = 1'b0;
        end else if (tx_state_q == TX_BUSY) begin
            ph_d   = ph_dec;
            aclk_d = (ph_dec < PH_HALF);
        end
        if (frame_end && hold_full_q) hold_full_d = 1'b0;
        // A request on the final edge of an unheld frame was launched directly above.
        if ((tx_state_q == TX_BUSY) && pixel_valid && !(frame_end && !hold_full_q)) begin
            if (!hold_full_q || frame_end) begin
                hold_full_d = 1'b1;
                hold_d      = pixel_data_in;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q      <= '0;
            ph_q        <= '0;
            bits_q      <= '0;
            aclk_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            ph_q        <= ph_d;
            bits_q      <= bits_d;
            aclk_q      <= aclk_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            ovf_q       <= ovf_d;
        end
    end

    assign apix_data   = sreg_q[26];
    assign apix_clk    = aclk_q;
    assign pixel_ready = ~hold_full_q;
    assign tx_overflow = ovf_q;

    rx_state_e   rx_state_q, rx_state_d;
    logic        clk_prev_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;
    logic        par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic [23:0] pdo_q, pdo_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic        rise, timeout;

    assign rise    = apix_clk_in & ~clk_prev_q;
    assign timeout = (rx_state_q != RX_IDLE) && !rise && (to_q == '0);

    always_ff @(posedge clk) begin
        if (rst) rx_state_q <= RX_IDLE;
        else     rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: if (rise && apix_data_in) rx_state_d = RX_DATA;
            RX_DATA: begin
                if (timeout)                     rx_state_d = RX_IDLE;
                else if (rise && (cnt_q == '0))  rx_state_d = RX_PAR;
            end
            RX_PAR: begin
                if (timeout)   rx_state_d = RX_IDLE;
                else if (rise) rx_state_d = RX_STOP;
            end
            RX_STOP: if (timeout || rise) rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        par_d = par_q;
        to_d  = to_q;
        pdo_d = pdo_q;
        vld_d = 1'b0;
        err_d = err_q;
        if (rise)                                        to_d = TO_LOAD;
        else if ((rx_state_q != RX_IDLE) && (to_q != '0)) to_d = to_q - TW'(1);
        case (rx_state_q)
            RX_IDLE: if (rise && apix_data_in) cnt_d = 5'd23;
            RX_DATA: if (rise) begin
                sh_d  = {sh_q[22:0], apix_data_in};
                cnt_d = cnt_q - 5'd1;
            end
            RX_PAR: if (rise) par_d = apix_data_in;
            RX_STOP: if (rise) begin
                if ((par_q == ^sh_q) && !apix_data_in) begin
                    pdo_d = sh_q;
                    vld_d = 1'b1;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        endcase
        if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_q <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            to_q       <= '0;
            pdo_q      <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_prev_q <= apix_clk_in;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            to_q       <= to_d;
            pdo_q      <= pdo_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    assign pixel_data_out  = pdo_q;
    assign pixel_out_valid = vld_q;
    assign error_flag      = err_q;

endmodule

// File: tb/tb_apix_link_core.sv
// Bench for apix_link_core: external loopback with injectable faults, a frame-level
// reference model compared every cycle, and directed checks with literal expectations.
module tb_apix_link_core;

    localparam int BC = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_data_in;
    logic        pixel_valid;
    logic        pixel_ready, tx_overflow, apix_data, apix_clk;
    logic        rx_d, rx_c;
    logic [23:0] pixel_data_out;
    logic        pixel_out_valid, error_flag;

    logic flip_en = 1'b0, kill_en = 1'b0;
    logic flip_q = 1'b0, kill_q = 1'b0;

    always #5 clk = ~clk;

    assign rx_d = apix_data ^ flip_q;
    assign rx_c = apix_clk & ~kill_q;

    apix_link_core #(.BIT_CYCLES(BC), .RX_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .pixel_data_in(pixel_data_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .tx_overflow(tx_overflow),
        .apix_data(apix_data), .apix_clk(apix_clk),
        .apix_data_in(rx_d), .apix_clk_in(rx_c),
        .pixel_data_out(pixel_data_out), .pixel_out_valid(pixel_out_valid),
        .error_flag(error_flag)
    );

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [26:0] mk_frame(input logic [23:0] p);
        return {1'b1, p, ^p, 1'b0};
    endfunction

    // Reference model state: TX frame timeline plus holding queue; RX as a bit list.
    bit          m_busy;
    int          m_start;
    logic [26:0] m_frame;
    logic [23:0] m_hold[$];
    bit          m_ovf;
    bit          e_data, e_clk;
    bit          m_prev, m_act;
    bit          rx_bits[$];
    int          m_idle;
    logic [23:0] e_pdo;
    bit          e_vld, e_err;

    task automatic m_launch(input logic [23:0] p);
        m_busy  = 1;
        m_start = cyc;
        m_frame = mk_frame(p);
    endtask

    always @(posedge clk) begin
        bit rise;
        int t;
        logic [23:0] d;
        cyc++;
        if (rst) begin
            started = 1;
            m_busy = 0; m_hold.delete(); m_ovf = 0;
            m_act = 0; rx_bits.delete(); m_idle = 0;
            e_pdo = '0; e_vld = 0; e_err = 0; m_prev = 0;
        end else begin
            if (m_busy && (cyc - m_start == 27 * BC)) begin
                if (m_hold.size() > 0) begin
                    m_launch(m_hold.pop_front());
                    if (pixel_valid) m_hold.push_back(pixel_data_in);
                end else if (pixel_valid) m_launch(pixel_data_in);
                else m_busy = 0;
            end else if (pixel_valid) begin
                if (!m_busy)                 m_launch(pixel_data_in);
                else if (m_hold.size() == 0) m_hold.push_back(pixel_data_in);
                else                         m_ovf = 1;
            end
            e_vld = 0;
            rise = rx_c && !m_prev;
            if (!m_act) begin
                if (rise && rx_d) begin
                    m_act = 1; rx_bits.delete(); m_idle = 0;
                end
            end else if (rise) begin
                rx_bits.push_back(rx_d);
                m_idle = 0;
                if (rx_bits.size() == 26) begin
                    d = '0;
                    for (int i = 0; i < 24; i++) d = {d[22:0], rx_bits[i]};
                    if ((rx_bits[24] == ^d) && (rx_bits[25] == 0)) begin
                        e_pdo = d; e_vld = 1; e_err = 0;
                    end else e_err = 1;
                    m_act = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    e_err = 1; m_act = 0;
                end
            end
            m_prev = rx_c;
        end
        if (m_busy) begin
            t = cyc - m_start;
            e_data = m_frame[26 - t / BC];
            e_clk  = (t % BC) >= BC / 2;
        end else begin
            t = 0; e_data = 0; e_clk = 0;
        end
        flip_q <= flip_en && m_busy && (t / BC == 25);
        kill_q <= kill_en && m_busy && (t / BC >= 9);
    end

    int          log_cyc[$];
    logic [23:0] log_dat[$];

    always @(negedge clk) begin
        if (started) begin
            chk("apix_data",       32'(apix_data),       32'(e_data));
            chk("apix_clk",        32'(apix_clk),        32'(e_clk));
            chk("pixel_ready",     32'(pixel_ready),     32'(m_hold.size() == 0));
            chk("tx_overflow",     32'(tx_overflow),     32'(m_ovf));
            chk("pixel_data_out",  32'(pixel_data_out),  32'(e_pdo));
            chk("pixel_out_valid", 32'(pixel_out_valid), 32'(e_vld));
            chk("error_flag",      32'(error_flag),      32'(e_err));
            if (pixel_out_valid === 1'b1) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(pixel_data_out);
            end
        end
    end

    task automatic send(input logic [23:0] p, output int acc);
        pixel_data_in = p;
        pixel_valid   = 1'b1;
        @(negedge clk);
        pixel_valid   = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_dat.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input int n0,
                           input int lat, input logic [23:0] pix);
        if (log_cyc.size() > idx) begin
            chk({name, "_lat"}, 32'(log_cyc[idx] - n0), 32'(lat));
            chk({name, "_pix"}, 32'(log_dat[idx]), 32'(pix));
        end else begin
            chk({name, "_present"}, 32'(log_cyc.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_data"},  32'(apix_data),       32'd0);
        chk({name, "_clk"},   32'(apix_clk),        32'd0);
        chk({name, "_ready"}, 32'(pixel_ready),     32'd1);
        chk({name, "_ovf"},   32'(tx_overflow),     32'd0);
        chk({name, "_pdo"},   32'(pixel_data_out),  32'd0);
        chk({name, "_vld"},   32'(pixel_out_valid), 32'd0);
        chk({name, "_err"},   32'(error_flag),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;
        logic [26:0] f1;
        f1 = 27'b1_111111110000000011111111_0_0;
        rst = 1'b1; pixel_valid = 1'b0; pixel_data_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: single pixel, exact bit stream and latency
        clear_log();
        send(24'hFF00FF, n);
        for (int k = 0; k < 27; k++) begin
            wait_cyc(n + k * BC);
            chk("t1_bit", 32'(apix_data), 32'(f1[26 - k]));
        end
        wait_cyc(n + 60);
        chk("t1_count", 32'(log_cyc.size()), 32'd1);
        chk_log("t1", 0, n, 54, 24'hFF00FF);
        chk("t1_err", 32'(error_flag), 32'd0);

        // 2: second pixel held, back-to-back frames
        clear_log();
        send(24'hFF00FF, n);
        repeat (2) @(negedge clk);
        send(24'h000001, n2);
        wait_cyc(n + 53);
        chk("t2_ready_busy", 32'(pixel_ready), 32'd0);
        wait_cyc(n + 54);
        chk("t2_ready_free", 32'(pixel_ready), 32'd1);
        chk("t2_start2", 32'(apix_data), 32'd1);
        wait_cyc(n + 104);
        chk("t2_parity2", 32'(apix_data), 32'd1);
        wait_cyc(n + 112);
        chk("t2_count", 32'(log_cyc.size()), 32'd2);
        chk_log("t2a", 0, n, 54, 24'hFF00FF);
        chk_log("t2b", 1, n, 108, 24'h000001);
        chk("t2_ovf", 32'(tx_overflow), 32'd0);

        // 3: third request in one frame is dropped
        clear_log();
        send(24'h111111, n);
        repeat (2) @(negedge clk);
        send(24'h222222, n2);
        repeat (2) @(negedge clk);
        send(24'h333333, n2);
        chk("t3_ovf_set", 32'(tx_overflow), 32'd1);
        wait_cyc(n + 120);
        chk("t3_count", 32'(log_cyc.size()), 32'd2);
        chk_log("t3a", 0, n, 54, 24'h111111);
        chk_log("t3b", 1, n, 108, 24'h222222);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_ovf_clr", 32'(tx_overflow), 32'd0);

        // 4: corrupted parity keeps old pixel, next good frame clears error
        clear_log();
        send(24'h0A0B0C, n);
        wait_cyc(n + 60);
        flip_en = 1'b1;
        send(24'h00FF00, n);
        wait_cyc(n + 60);
        flip_en = 1'b0;
        chk("t4_err", 32'(error_flag), 32'd1);
        chk("t4_pdo_held", 32'(pixel_data_out), 32'h0A0B0C);
        chk("t4_count", 32'(log_cyc.size()), 32'd1);
        send(24'h123456, n);
        wait_cyc(n + 60);
        chk("t4_err_clr", 32'(error_flag), 32'd0);
        chk("t4_pdo_new", 32'(pixel_data_out), 32'h123456);

        // 5: strobe stalls from bit 9; timeout 8 cycles after last rising edge
        kill_en = 1'b1;
        send(24'h5A5A5A, n);
        wait_cyc(n + 25);
        chk("t5_err_before", 32'(error_flag), 32'd0);
        wait_cyc(n + 26);
        chk("t5_err_timeout", 32'(error_flag), 32'd1);
        wait_cyc(n + 60);
        kill_en = 1'b0;
        clear_log();
        send(24'h777777, n);
        wait_cyc(n + 60);
        chk("t5_count", 32'(log_cyc.size()), 32'd1);
        chk_log("t5", 0, n, 54, 24'h777777);
        chk("t5_err_clr", 32'(error_flag), 32'd0);

        // 6: reset mid-frame
        send(24'h135790, n);
        wait_cyc(n + 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("t6_reset");
        clear_log();
        send(24'hABCDEF, n);
        wait_cyc(n + 60);
        chk("t6_count", 32'(log_cyc.size()), 32'd1);
        chk_log("t6", 0, n, 54, 24'hABCDEF);

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            pixel_valid   = ($urandom_range(0, 29) == 0);
            pixel_data_in = 24'($urandom);
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        repeat (200) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
